// File: rtl/tcm_dual_master_arbiter_if.sv
// Bus bundle between two Avalon-MM masters, the TCM arbiter and the RAM s1 port.
// slave = arbiter view, master = masters-plus-RAM environment view.
interface tcm_dual_master_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  m0_address, m0_byteenable,
    input  m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata,
    output m0_readdatavalid,
    input  m1_address, m1_byteenable,
    input  m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata,
    output m1_readdatavalid,
    output mem_address, mem_byteenable,
    output mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output m0_address, m0_byteenable,
    output m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata,
    input  m0_readdatavalid,
    output m1_address, m1_byteenable,
    output m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata,
    input  m1_readdatavalid,
    input  mem_address, mem_byteenable,
    input  mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/tcm_dual_master_arbiter.sv
// Round-robin arbiter sharing one TCM port between two masters, optional zero-fill.
// Define TCM_ARB_PERF_CNT_EN to add stall/conflict performance counters.
module tcm_dual_master_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int BE_W           = 4,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic reset,
  tcm_dual_master_arbiter_if.slave bus,
`ifdef TCM_ARB_PERF_CNT_EN
  input  logic        perf_clear,
  output logic [31:0] perf_m0_stall,
  output logic [31:0] perf_m1_stall,
  output logic [31:0] perf_conflict,
`endif
  output logic init_done
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RST  =
    (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              last_grant_q, last_grant_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;

  logic run, req0, req1, gnt0, gnt1, rd_acc;

  always_comb begin
    run  = (state_q == ST_RUN);
    req0 = bus.m0_read | bus.m0_write;
    req1 = bus.m1_read | bus.m1_write;
    // on a tie the master not served last wins
    gnt0 = run & req0 & (~req1 | last_grant_q);
    gnt1 = run & req1 & (~req0 | ~last_grant_q);
    rd_acc = (gnt0 & bus.m0_read & ~bus.m0_write)
           | (gnt1 & bus.m1_read & ~bus.m1_write);

    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    last_grant_d = last_grant_q;
    rd_pend_d    = rd_acc;
    rd_owner_d   = rd_owner_q;

    if (!run) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
    end
    if (gnt0 | gnt1) last_grant_d = gnt1;
    if (rd_acc) rd_owner_d = gnt1;
  end

  always_comb begin
    bus.m0_waitrequest   = ~gnt0;
    bus.m1_waitrequest   = ~gnt1;
    bus.m0_readdata      = bus.mem_readdata;
    bus.m1_readdata      = bus.mem_readdata;
    bus.m0_readdatavalid = rd_pend_q & ~rd_owner_q;
    bus.m1_readdatavalid = rd_pend_q & rd_owner_q;
    bus.mem_clken        = 1'b1;
    init_done            = run;

    if (!run) begin
      bus.mem_address    = clr_addr_q;
      bus.mem_byteenable = '1;
      bus.mem_writedata  = '0;
      bus.mem_chipselect = 1'b1;
      bus.mem_write      = 1'b1;
    end else if (gnt1) begin
      bus.mem_address    = bus.m1_address;
      bus.mem_byteenable = bus.m1_byteenable;
      bus.mem_writedata  = bus.m1_writedata;
      bus.mem_chipselect = 1'b1;
      bus.mem_write      = bus.m1_write;
    end else begin
      bus.mem_address    = bus.m0_address;
      bus.mem_byteenable = bus.m0_byteenable;
      bus.mem_writedata  = bus.m0_writedata;
      bus.mem_chipselect = gnt0;
      bus.mem_write      = gnt0 & bus.m0_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RST;
      clr_addr_q   <= '0;
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

`ifdef TCM_ARB_PERF_CNT_EN
  logic [31:0] st0_q, st0_d;
  logic [31:0] st1_q, st1_d;
  logic [31:0] cfl_q, cfl_d;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        ev
  );
    return (ev && v != '1) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    st0_d = sat_inc(st0_q, run & req0 & ~gnt0);
    st1_d = sat_inc(st1_q, run & req1 & ~gnt1);
    cfl_d = sat_inc(cfl_q, run & req0 & req1);
    if (perf_clear) begin
      st0_d = '0;
      st1_d = '0;
      cfl_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st0_q <= '0;
      st1_q <= '0;
      cfl_q <= '0;
    end else begin
      st0_q <= st0_d;
      st1_q <= st1_d;
      cfl_q <= cfl_d;
    end
  end

  assign perf_m0_stall = st0_q;
  assign perf_m1_stall = st1_q;
  assign perf_conflict = cfl_q;
`endif

endmodule

// File: tb/tb_tcm_dual_master_arbiter.sv
// Bench for tcm_dual_master_arbiter: RAM model, directed plus random traffic.
// Perf counter checks compile in with TCM_ARB_PERF_CNT_EN.
module tb_tcm_dual_master_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic init_done;
  always #5 clk = ~clk;

  tcm_dual_master_arbiter_if bus ();

`ifdef TCM_ARB_PERF_CNT_EN
  logic        perf_clear;
  logic [31:0] pm0, pm1, pcf;
`endif

  tcm_dual_master_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
`ifdef TCM_ARB_PERF_CNT_EN
    .perf_clear    (perf_clear),
    .perf_m0_stall (pm0),
    .perf_m1_stall (pm1),
    .perf_conflict (pcf),
`endif
    .init_done (init_done)
  );

  // altsyncram-like RAM: registered address, unregistered q
  logic [31:0] ram [1024];
  logic [9:0]  ram_a;
  always @(posedge clk) begin
    if (bus.mem_clken) begin
      ram_a <= bus.mem_address;
      if (bus.mem_chipselect && bus.mem_write)
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b])
            ram[bus.mem_address][b*8 +: 8]
              <= bus.mem_writedata[b*8 +: 8];
    end
  end
  assign bus.mem_readdata = ram[ram_a];

  // reference model
  logic [31:0] gm [1024];
  int          last;
  bit          pv0, pv1;
  logic [31:0] pd;
  int          g;
  bit          g_rd, g_wr;
  logic [9:0]  g_a;
  logic [3:0]  g_be;
  logic [31:0] g_wd;
  int          st0, st1, cf;
  int          errors = 0;
  int          checks = 0;
  bit          rq [2];
  bit          hold [2];

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(
    input int          m,
    input bit          rd,
    input bit          wr,
    input logic [9:0]  a,
    input logic [3:0]  be,
    input logic [31:0] d
  );
    if (m == 0) begin
      bus.m0_read = rd; bus.m0_write = wr;
      bus.m0_address = a; bus.m0_byteenable = be;
      bus.m0_writedata = d;
    end else begin
      bus.m1_read = rd; bus.m1_write = wr;
      bus.m1_address = a; bus.m1_byteenable = be;
      bus.m1_writedata = d;
    end
    rq[m] = rd | wr;
  endtask

  task automatic idle();
    drv(0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, '0, '0, '0);
  endtask

  task automatic chk_cycle();
    bit r0, r1;
    r0 = bus.m0_read | bus.m0_write;
    r1 = bus.m1_read | bus.m1_write;
    if (r0 && r1) g = 1 - last;
    else if (r0)  g = 0;
    else if (r1)  g = 1;
    else          g = -1;
    g_rd = 0; g_wr = 0;
    if (g == 0) begin
      g_a = bus.m0_address; g_be = bus.m0_byteenable;
      g_wd = bus.m0_writedata; g_wr = bus.m0_write;
      g_rd = bus.m0_read & ~bus.m0_write;
    end else if (g == 1) begin
      g_a = bus.m1_address; g_be = bus.m1_byteenable;
      g_wd = bus.m1_writedata; g_wr = bus.m1_write;
      g_rd = bus.m1_read & ~bus.m1_write;
    end
    if (r0) chk("wait0", 32'(bus.m0_waitrequest), 32'(g != 0));
    if (r1) chk("wait1", 32'(bus.m1_waitrequest), 32'(g != 1));
    chk("mem_cs", 32'(bus.mem_chipselect), 32'(g >= 0));
    chk("mem_wr", 32'(bus.mem_write), 32'(g_wr));
    if (g >= 0)
      chk("mem_addr", 32'(bus.mem_address), 32'(g_a));
    if (g_wr) begin
      chk("mem_be", 32'(bus.mem_byteenable), 32'(g_be));
      chk("mem_wd", bus.mem_writedata, g_wd);
    end
    chk("rdv0", 32'(bus.m0_readdatavalid), 32'(pv0));
    chk("rdv1", 32'(bus.m1_readdatavalid), 32'(pv1));
    if (pv0) chk("rdata0", bus.m0_readdata, pd);
    if (pv1) chk("rdata1", bus.m1_readdata, pd);
    if (r0 && g != 0) st0++;
    if (r1 && g != 1) st1++;
    if (r0 && r1) cf++;
  endtask

  task automatic adv();
    @(posedge clk);
    if (g >= 0) begin
      if (g_wr)
        for (int b = 0; b < 4; b++)
          if (g_be[b]) gm[g_a][b*8 +: 8] = g_wd[b*8 +: 8];
      last = g;
    end
    pv0 = (g == 0) && g_rd;
    pv1 = (g == 1) && g_rd;
    if (g_rd) pd = gm[g_a];
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    chk_cycle();
    adv();
  endtask

  initial begin
    int n;
    int op;
    reset = 1'b1;
    idle();
`ifdef TCM_ARB_PERF_CNT_EN
    perf_clear = 1'b0;
`endif
    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      gm[i] = '0;
    end
    last = 1; pv0 = 0; pv1 = 0; pd = '0;
    st0 = 0; st1 = 0; cf = 0;
    hold[0] = 0; hold[1] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_wait0", 32'(bus.m0_waitrequest), 32'd1);
    chk("rst_wait1", 32'(bus.m1_waitrequest), 32'd1);
    chk("rst_rdv0", 32'(bus.m0_readdatavalid), 32'd0);
    chk("rst_rdv1", 32'(bus.m1_readdatavalid), 32'd0);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // zero-fill while m0 holds a stalled read of the top word
    drv(0, 1, 0, 10'h3FF, 4'hF, '0);
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (init_done) break;
      chk("init_wait0", 32'(bus.m0_waitrequest), 32'd1);
      chk("init_addr", 32'(bus.mem_address), 32'(n));
      chk("init_ctl",
          32'({bus.mem_chipselect, bus.mem_write,
               bus.mem_byteenable}), 32'h3F);
      chk("init_wd", bus.mem_writedata, 32'd0);
      n++;
      @(posedge clk);
      #1;
    end
    chk("init_len", 32'(n), 32'd1024);
    if (!init_done) begin
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $fatal(1, "init never completed");
    end
    chk("init_done", 32'(init_done), 32'd1);
    chk_cycle();
    adv();
    idle();
    @(negedge clk);
    chk("zf_rdv0", 32'(bus.m0_readdatavalid), 32'd1);
    chk("zf_rdata", bus.m0_readdata, 32'd0);
    chk_cycle();
    adv();

    // write then read back-to-back on m0
    drv(0, 0, 1, 10'h010, 4'hF, 32'hDEADBEEF);
    cyc();
    drv(0, 1, 0, 10'h010, 4'hF, '0);
    cyc();
    idle();
    @(negedge clk);
    chk("pipe_rdata", bus.m0_readdata, 32'hDEADBEEF);
    chk_cycle();
    adv();

    // byte lanes on m1
    drv(1, 0, 1, 10'h020, 4'hF, 32'hAABBCCDD);
    cyc();
    drv(1, 0, 1, 10'h020, 4'b0101, 32'h11223344);
    cyc();
    drv(1, 1, 0, 10'h020, 4'hF, '0);
    cyc();
    idle();
    @(negedge clk);
    chk("be_rdata", bus.m1_readdata, 32'hAA22CC44);
    chk_cycle();
    adv();

`ifdef TCM_ARB_PERF_CNT_EN
    st0 = 0; st1 = 0; cf = 0;
    chk("pc_pre", pcf, 32'd0);
`endif
    // round-robin with both masters reading every cycle
    for (int k = 0; k < 6; k++) begin
      drv(0, 1, 0, 10'h010, 4'hF, '0);
      drv(1, 1, 0, 10'h020, 4'hF, '0);
      @(negedge clk);
      chk("rr_wait0", 32'(bus.m0_waitrequest), 32'(k % 2));
      chk_cycle();
      adv();
    end
    idle();
    cyc();
`ifdef TCM_ARB_PERF_CNT_EN
    chk("rr_conflict", pcf, 32'd6);
    chk("rr_stall0", pm0, 32'd3);
    chk("rr_stall1", pm1, 32'd3);
    drv(0, 1, 0, 10'h010, 4'hF, '0);
    drv(1, 1, 0, 10'h020, 4'hF, '0);
    perf_clear = 1'b1;
    cyc();
    perf_clear = 1'b0;
    idle();
    cyc();
    chk("clr_conflict", pcf, 32'd0);
    chk("clr_stall0", pm0, 32'd0);
    chk("clr_stall1", pm1, 32'd0);
    st0 = 0; st1 = 0; cf = 0;
`endif

    // read+write together counts as a write only
    drv(0, 1, 1, 10'h030, 4'hF, 32'h12345678);
    cyc();
    idle();
    @(negedge clk);
    chk("rw_rdv0", 32'(bus.m0_readdatavalid), 32'd0);
    chk_cycle();
    adv();
    drv(1, 1, 0, 10'h030, 4'hF, '0);
    cyc();
    idle();
    cyc();

    // random traffic, stalled requests held
    for (int k = 0; k < 300; k++) begin
      for (int m = 0; m < 2; m++) begin
        if (!hold[m]) begin
          op = int'($urandom_range(0, 3));
          drv(m, op[0], op[1],
              10'h040 + 10'($urandom_range(0, 15)),
              4'($urandom), $urandom);
        end
      end
      cyc();
      hold[0] = rq[0] && (g != 0);
      hold[1] = rq[1] && (g != 1);
    end
    idle();
    cyc();
`ifdef TCM_ARB_PERF_CNT_EN
    chk("rnd_stall0", pm0, 32'(st0));
    chk("rnd_stall1", pm1, 32'(st1));
    chk("rnd_conflict", pcf, 32'(cf));
`endif

    // reset in the cycle after an accepted m1 read
    drv(1, 1, 0, 10'h040, 4'hF, '0);
    @(negedge clk);
    chk_cycle();
    adv();
    reset = 1'b1;
    idle();
    @(negedge clk);
    chk("mr_rdv1", 32'(bus.m1_readdatavalid), 32'd0);
    chk("mr_done", 32'(init_done), 32'd0);
    chk("mr_addr", 32'(bus.mem_address), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mr_addr0", 32'(bus.mem_address), 32'd0);
    chk("mr_rdv1b", 32'(bus.m1_readdatavalid), 32'd0);
    @(negedge clk);
    chk("mr_addr1", 32'(bus.mem_address), 32'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
